dff_pipe: RTL and testbench
===========================

Name: dff_pipe

Overview:
- Parametrised multi-stage register pipeline with a per-stage valid flag, stall (enable) control, flush and an occupancy count.
- Replaces single-bit storage elements wherever a bus must be delayed a fixed number of cycles with flow control.
- Sits between datapath blocks as a retiming and delay element.
- Fully synchronous, single clock domain.

Parameters:
- WIDTH, 8, data bus width in bits (>=1).
- DEPTH, 3, number of register stages (>=1); latency in enabled cycles.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  advance enable; 1 shifts all stages by one, 0 holds all stages.
- flush  input  1  synchronous clear of all valid flags.
- d  input  WIDTH  input data.
- d_valid  input  1  qualifies d.
- q  output  WIDTH  data of the last stage.
- q_valid  output  1  valid flag of the last stage.
- count  output  CNT_W  number of stages currently holding valid data.

Behaviour:
- Stage 0 is the input stage; stage DEPTH-1 drives q and q_valid.
- Reset: on a clk edge with rst=1, all stage data is set to 0, all valid flags to 0, and count to 0.
  - rst overrides en and flush.
  - Outputs are 0 from the first edge with rst high.
  - Reset mid-stream discards all in-flight data.
- Priority per edge: rst > flush > en.
- flush=1 (rst=0):
  - All valid flags clear.
  - count becomes 0.
  - Data registers keep their values; no shift occurs.
  - d is not captured, even if en=1.
- en=1 (rst=0, flush=0):
  - stage[0] <= {d, d_valid}.
  - stage[i] <= stage[i-1] for i = 1..DEPTH-1.
  - The previous last-stage contents are dropped; no backpressure is applied to the consumer.
- en=0: all stages and count hold their values.
- Latency: d presented with en=1 at edge k appears on q after edge k+DEPTH-1, provided en=1 on each of those edges. Hold cycles extend latency 1:1.
- DEPTH=1: single register; q follows d one enabled edge later.
- count:
  - Registered; equals the popcount of the valid flags after each edge.
  - On a shift it changes by +1 when d_valid is captured and the last stage was invalid.
  - It changes by -1 when d_valid=0 and the last stage was valid; otherwise it is unchanged.
  - Range 0..DEPTH; it never wraps.
- Bubbles (d_valid=0 with en=1) propagate as invalid stages. The data values inside a bubble are still shifted.
- No combinational path from any input to any output.

Optional Feature:
- Macro: DFF_PIPE_ZERO_INVALID_EN.
- Defined: q is forced to all zeros whenever q_valid=0, by gating at the output. Internal stage data is unaffected.
- Undefined: q shows the raw last-stage data regardless of q_valid. After reset that data is 0; after a flush it is the stale pre-flush value.

Decomposition:
- Package dff_pipe_pkg holds:
  - The default constants DFF_PIPE_WIDTH_DEF=8 and DFF_PIPE_DEPTH_DEF=3.
  - A count-width function clog2_plus1(depth) used to derive CNT_W.
- Sub-module dff_stage: one WIDTH+1-bit register with synchronous active-high reset, load enable and valid-clear input.
  - dff_pipe instantiates DEPTH copies in a generate loop.
  - dff_pipe owns the count register.

Test Plan:
- Reset: rst=1 for 2 edges with d=8'hFF, d_valid=1, en=1 -> q=0, q_valid=0, count=0 after the first edge. No capture while rst is high.
- Latency (DEPTH=3): en=1, d=8'h11/22/33 with d_valid=1 on 3 consecutive edges -> q=8'h11 with q_valid=1 after the 3rd edge, then 8'h22, then 8'h33; count reaches 3.
- Stall: load 8'hA5 with en=1, then en=0 for 4 cycles -> all stages, q and count frozen; the shift resumes exactly when en=1 returns.
- Flush vs en: pipe full (count=3), flush=1 with en=1, d=8'h77, d_valid=1 -> count=0 and q_valid=0 next cycle. 8'h77 never appears on q. With the macro defined, q=0.
- Bubbles: pattern d_valid=1,0,1 with en=1 -> q_valid=1,0,1 on the 3rd-5th edges; count follows the popcount and peaks at 2.
- Mid-stream reset: pipe holding 2 valid words, rst=1 for 1 edge -> q=0, q_valid=0, count=0. After a single new word is pushed, count becomes 1, and a DEPTH=1 build passes the same scenarios with latency 1.

Source files
------------

// File: rtl/dff_pipe_pkg.sv
// dff_pipe_pkg: shared constants and helpers for the dff_pipe register pipeline.
//
// Contents:
//   DFF_PIPE_WIDTH_DEF  default data bus width
//   DFF_PIPE_DEPTH_DEF  default number of register stages
//   clog2_plus1(depth)  bits needed to hold any value 0..depth (occupancy count width)
package dff_pipe_pkg;

    localparam int DFF_PIPE_WIDTH_DEF = 8;
    localparam int DFF_PIPE_DEPTH_DEF = 3;

    // Always at least one bit, so a DEPTH=1 pipe still gets a usable count.
    function automatic int clog2_plus1(input int depth);
        int w;
        w = 1;
        while ((1 << w) < (depth + 1)) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/dff_stage.sv
// dff_stage: one pipeline stage holding WIDTH data bits plus a valid flag.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; clears data and valid
//   load       capture {d, d_valid} on this edge
//   clr_valid  clear the valid flag and keep the data (beats load)
//   d          incoming data
//   d_valid    incoming valid flag
//   q          stored data
//   q_valid    stored valid flag
module dff_stage
    import dff_pipe_pkg::*;
#(
    parameter int WIDTH = DFF_PIPE_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clr_valid,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    logic [WIDTH-1:0] data_d, data_q;
    logic             valid_d, valid_q;

    // Clearing the valid flag leaves the data alone, so the stale word stays
    // visible downstream.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (clr_valid) begin
            valid_d = 1'b0;
        end else if (load) begin
            data_d  = d;
            valid_d = d_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign q       = data_q;
    assign q_valid = valid_q;

endmodule

// File: rtl/dff_pipe.sv
// dff_pipe: DEPTH-stage register pipeline with per-stage valid flags, stall
// (en), flush and a registered occupancy count.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset (beats flush, which beats en)
//   en       1 shifts every stage by one, 0 holds everything
//   flush    clears all valid flags and the count; data is kept, d is not captured
//   d        input data (WIDTH bits)
//   d_valid  qualifies d
//   q        data of the last stage
//   q_valid  valid flag of the last stage
//   count    number of stages holding valid data (0..DEPTH)
//
// Build option: define DFF_PIPE_ZERO_INVALID_EN to force q to zero while
// q_valid is low. The gating sits on the output only; stage data is unchanged.
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int WIDTH = DFF_PIPE_WIDTH_DEF,
    parameter int DEPTH = DFF_PIPE_DEPTH_DEF,
    parameter int CNT_W = clog2_plus1(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] stage_data  [DEPTH];
    logic             stage_valid [DEPTH];
    logic [CNT_W-1:0] count_d, count_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] in_data;
        logic             in_valid;

        if (i == 0) begin : g_first
            assign in_data  = d;
            assign in_valid = d_valid;
        end else begin : g_rest
            assign in_data  = stage_data[i-1];
            assign in_valid = stage_valid[i-1];
        end

        dff_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .load     (en),
            .clr_valid(flush),
            .d        (in_data),
            .d_valid  (in_valid),
            .q        (stage_data[i]),
            .q_valid  (stage_valid[i])
        );
    end

    // Tracking the count incrementally avoids a popcount tree: a shift gains
    // the incoming valid and loses the valid falling off the end. The sum
    // stays within 0..DEPTH even though the intermediate difference may wrap.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CNT_W'(d_valid) - CNT_W'(stage_valid[DEPTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

`ifdef DFF_PIPE_ZERO_INVALID_EN
    assign q = stage_valid[DEPTH-1] ? stage_data[DEPTH-1] : '0;
`else
    assign q = stage_data[DEPTH-1];
`endif
    assign q_valid = stage_valid[DEPTH-1];
    assign count   = count_q;

endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: self-checking bench for dff_pipe.
// Two instances share the same stimulus: DEPTH=3 (default) and DEPTH=1.
// The reference model is a history of every word accepted by the pipe; the
// word shown by a DEPTH=N pipe is the N-th most recent entry, and its count is
// the number of valid entries among the N most recent ones. Reset refills the
// history with zero words, and flush invalidates every entry while keeping its data.
module tb_dff_pipe;

    localparam int WIDTH    = 8;
    localparam int HIST_MAX = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] d = '0;
    logic             d_valid = 1'b0;

    logic [WIDTH-1:0] q3, q1;
    logic             qv3, qv1;
    logic [1:0]       cnt3;
    logic [0:0]       cnt1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             valid;
    } entry_t;

    entry_t hist[$];

    dff_pipe #(
        .WIDTH(WIDTH),
        .DEPTH(3)
    ) dut3 (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .flush  (flush),
        .d      (d),
        .d_valid(d_valid),
        .q      (q3),
        .q_valid(qv3),
        .count  (cnt3)
    );

    dff_pipe #(
        .WIDTH(WIDTH),
        .DEPTH(1)
    ) dut1 (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .flush  (flush),
        .d      (d),
        .d_valid(d_valid),
        .q      (q1),
        .q_valid(qv1),
        .count  (cnt1)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, let the edge happen, update the model and
    // settle 1 time unit past the edge so outputs are sampled away from it.
    task automatic applyStimulus(input logic r, input logic e, input logic f,
                                 input logic [WIDTH-1:0] dd, input logic dv);
        entry_t ent;
        rst     = r;
        en      = e;
        flush   = f;
        d       = dd;
        d_valid = dv;
        @(posedge clk);
        if (r) begin
            hist.delete();
            ent.data  = '0;
            ent.valid = 1'b0;
            for (int i = 0; i < 3; i++) hist.push_back(ent);
        end else if (f) begin
            foreach (hist[i]) hist[i].valid = 1'b0;
        end else if (e) begin
            ent.data  = dd;
            ent.valid = dv;
            hist.push_back(ent);
            if (hist.size() > HIST_MAX) void'(hist.pop_front());
        end
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int validInLast(input int n);
        int c;
        c = 0;
        for (int i = 0; i < n; i++) c += int'(hist[hist.size() - 1 - i].valid);
        return c;
    endfunction

    task automatic checkOutput(input string tag);
        entry_t           e3, e1;
        logic [WIDTH-1:0] x3, x1;
        e3 = hist[hist.size() - 3];
        e1 = hist[hist.size() - 1];
        x3 = e3.data;
        x1 = e1.data;
`ifdef DFF_PIPE_ZERO_INVALID_EN
        if (!e3.valid) x3 = '0;
        if (!e1.valid) x1 = '0;
`endif
        check({tag, ".q3"},   32'(q3),   32'(x3));
        check({tag, ".qv3"},  32'(qv3),  32'(e3.valid));
        check({tag, ".cnt3"}, 32'(cnt3), 32'(validInLast(3)));
        check({tag, ".q1"},   32'(q1),   32'(x1));
        check({tag, ".qv1"},  32'(qv1),  32'(e1.valid));
        check({tag, ".cnt1"}, 32'(cnt1), 32'(validInLast(1)));
    endtask

    initial begin
        // Reset held for two edges while en/d_valid try to capture 0xFF.
        applyStimulus(1'b1, 1'b1, 1'b0, 8'hFF, 1'b1);
        checkOutput("rst1");
        check("rst1.q3_zero", 32'(q3), 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'hFF, 1'b1);
        checkOutput("rst2");

        // Latency: three words, then bubbles to drain them.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h11, 1'b1);
        checkOutput("lat1");
        check("lat1.q1_hard", 32'(q1), 32'h11);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h22, 1'b1);
        checkOutput("lat2");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h33, 1'b1);
        checkOutput("lat3");
        check("lat3.q3_hard", 32'(q3), 32'h11);
        check("lat3.cnt3_hard", 32'(cnt3), 32'd3);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("lat4");
        check("lat4.q3_hard", 32'(q3), 32'h22);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("lat5");
        check("lat5.q3_hard", 32'(q3), 32'h33);

        // Stall: load 0xA5 then hold for four cycles while d keeps changing.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hA5, 1'b1);
        checkOutput("stall_load");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, WIDTH'($urandom), 1'b1);
            checkOutput($sformatf("stall_hold%0d", i));
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'h5A, 1'b0);
            checkOutput($sformatf("stall_resume%0d", i));
        end
        check("stall.q3_hard", 32'(q3), 32'hA5);

        // Flush beats en: fill the pipe, then flush while offering 0x77.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h01, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h02, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h03, 1'b1);
        checkOutput("flush_full");
        check("flush_full.cnt3_hard", 32'(cnt3), 32'd3);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h77, 1'b1);
        checkOutput("flush");
        check("flush.cnt3_hard", 32'(cnt3), 32'd0);
        check("flush.qv3_hard", 32'(qv3), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            checkOutput($sformatf("flush_drain%0d", i));
        end

        // Bubbles: valid, bubble, valid, then drain.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("bub_rst");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hB1, 1'b1);
        checkOutput("bub1");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hB2, 1'b0);
        checkOutput("bub2");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hB3, 1'b1);
        checkOutput("bub3");
        check("bub3.cnt3_hard", 32'(cnt3), 32'd2);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("bub4");
        check("bub4.qv3_hard", 32'(qv3), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("bub5");

        // Mid-stream reset with two words in flight, then a single new word.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hC1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hC2, 1'b1);
        checkOutput("mid_fill");
        applyStimulus(1'b1, 1'b1, 1'b0, 8'hC3, 1'b1);
        checkOutput("mid_rst");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hC4, 1'b1);
        checkOutput("mid_push");
        check("mid_push.cnt3_hard", 32'(cnt3), 32'd1);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 300; i++) begin
            logic r, e, f, v;
            r = ($urandom_range(0, 49) == 0);
            f = ($urandom_range(0, 9) == 0);
            e = ($urandom_range(0, 3) != 0);
            v = $urandom_range(0, 1) == 1;
            applyStimulus(r, e, f, WIDTH'($urandom), v);
            checkOutput($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
